// File: rtl/wb_arbiter.sv
// Write-back arbiter: merges ALU and LSU results onto one register-file write port.
// Define WB_ARB_ROUND_ROBIN_EN for round-robin grants; default is fixed LSU priority.
package pkg_config;
    localparam int DATA_WIDTH   = 32;
    localparam int NUM_REGISTER = 32;
endpackage

module wb_arbiter #(
    parameter int  DATA_WIDTH   = pkg_config::DATA_WIDTH,
    parameter int  NUM_REGISTER = pkg_config::NUM_REGISTER,
    localparam int AW           = $clog2(NUM_REGISTER)
) (
    input  logic                    clk_i,
    input  logic                    rst_n_i,
    input  logic                    alu_valid_i,
    output logic                    alu_ready_o,
    input  logic [AW-1:0]           alu_rd_addr_i,
    input  logic [DATA_WIDTH-1:0]   alu_data_i,
    input  logic                    lsu_valid_i,
    output logic                    lsu_ready_o,
    input  logic [AW-1:0]           lsu_rd_addr_i,
    input  logic [DATA_WIDTH-1:0]   lsu_data_i,
    output logic                    rf_we_o,
    output logic [AW-1:0]           rf_rd_addr_o,
    output logic [DATA_WIDTH-1:0]   rf_rd_o,
    output logic [NUM_REGISTER-1:0] pending_o,
    output logic                    busy_o
);

    logic                  alu_v;
    logic [AW-1:0]         alu_addr;
    logic [DATA_WIDTH-1:0] alu_data;
    logic                  lsu_v;
    logic [AW-1:0]         lsu_addr;
    logic [DATA_WIDTH-1:0] lsu_data;

    logic                  grant_alu;
    logic                  grant_lsu;
    logic                  alu_accept;
    logic                  lsu_accept;
    logic [AW-1:0]         sel_addr;
    logic [DATA_WIDTH-1:0] sel_data;
    logic                  sel_we;

`ifdef WB_ARB_ROUND_ROBIN_EN
    // prio_lsu set means LSU wins the next tie; flips only on a grant
    logic prio_lsu;

    always_comb begin
        grant_lsu = lsu_v & (~alu_v | prio_lsu);
        grant_alu = alu_v & (~lsu_v | ~prio_lsu);
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            prio_lsu <= 1'b1;
        end else if (grant_alu | grant_lsu) begin
            prio_lsu <= grant_alu;
        end
    end
`else
    always_comb begin
        grant_lsu = lsu_v;
        grant_alu = alu_v & ~lsu_v;
    end
`endif

    // A buffer being granted this cycle can take a new entry at the same edge
    assign alu_ready_o = ~alu_v | grant_alu;
    assign lsu_ready_o = ~lsu_v | grant_lsu;
    assign alu_accept  = alu_valid_i & alu_ready_o;
    assign lsu_accept  = lsu_valid_i & lsu_ready_o;

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            alu_v    <= 1'b0;
            alu_addr <= '0;
            alu_data <= '0;
        end else if (alu_accept) begin
            alu_v    <= 1'b1;
            alu_addr <= alu_rd_addr_i;
            alu_data <= alu_data_i;
        end else if (grant_alu) begin
            alu_v    <= 1'b0;
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            lsu_v    <= 1'b0;
            lsu_addr <= '0;
            lsu_data <= '0;
        end else if (lsu_accept) begin
            lsu_v    <= 1'b1;
            lsu_addr <= lsu_rd_addr_i;
            lsu_data <= lsu_data_i;
        end else if (grant_lsu) begin
            lsu_v    <= 1'b0;
        end
    end

    // Writes to x0 still consume their grant but never reach the port
    always_comb begin
        sel_addr = grant_lsu ? lsu_addr : alu_addr;
        sel_data = grant_lsu ? lsu_data : alu_data;
        sel_we   = (grant_lsu | grant_alu) && (sel_addr != '0);
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            rf_we_o      <= 1'b0;
            rf_rd_addr_o <= '0;
            rf_rd_o      <= '0;
        end else begin
            rf_we_o <= sel_we;
            if (sel_we) begin
                rf_rd_addr_o <= sel_addr;
                rf_rd_o      <= sel_data;
            end
        end
    end

    always_comb begin
        pending_o = '0;
        if (alu_v)   pending_o[alu_addr]     = 1'b1;
        if (lsu_v)   pending_o[lsu_addr]     = 1'b1;
        if (rf_we_o) pending_o[rf_rd_addr_o] = 1'b1;
        pending_o[0] = 1'b0;
    end

    assign busy_o = alu_v | lsu_v | rf_we_o;

endmodule

// File: tb/tb_wb_arbiter.sv
// Directed self-checking bench for wb_arbiter.
// Inputs change and outputs are sampled on the falling clock edge.
module tb_wb_arbiter;

    localparam int DW = 32;
    localparam int NR = 32;
    localparam int AW = 5;

    logic          clk;
    logic          rst_n;
    logic          alu_valid;
    logic          alu_ready;
    logic [AW-1:0] alu_rd;
    logic [DW-1:0] alu_data;
    logic          lsu_valid;
    logic          lsu_ready;
    logic [AW-1:0] lsu_rd;
    logic [DW-1:0] lsu_data;
    logic          rf_we;
    logic [AW-1:0] rf_addr;
    logic [DW-1:0] rf_data;
    logic [NR-1:0] pending;
    logic          busy;

    int checks = 0;
    int errors = 0;

    logic [DW-1:0] regfile [NR];

    wb_arbiter dut (
        .clk_i         (clk),
        .rst_n_i       (rst_n),
        .alu_valid_i   (alu_valid),
        .alu_ready_o   (alu_ready),
        .alu_rd_addr_i (alu_rd),
        .alu_data_i    (alu_data),
        .lsu_valid_i   (lsu_valid),
        .lsu_ready_o   (lsu_ready),
        .lsu_rd_addr_i (lsu_rd),
        .lsu_data_i    (lsu_data),
        .rf_we_o       (rf_we),
        .rf_rd_addr_o  (rf_addr),
        .rf_rd_o       (rf_data),
        .pending_o     (pending),
        .busy_o        (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (rf_we) regfile[rf_addr] <= rf_data;
    end

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

    task automatic test_reset();
        rst_n = 1'b0;
        alu_valid = 1'b0; alu_rd = '0; alu_data = '0;
        lsu_valid = 1'b0; lsu_rd = '0; lsu_data = '0;
        #12;
        checks++;
        if (rf_we !== 1'b0 || rf_addr !== 5'd0 || rf_data !== 32'd0) begin
            errors++;
            $display("FAIL reset_rf got we=%b a=%0d d=%h want 0 0 0",
                     rf_we, rf_addr, rf_data);
        end
        checks++;
        if (pending !== 32'd0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL reset_state got pend=%h busy=%b want 0 0",
                     pending, busy);
        end
        checks++;
        if (alu_ready !== 1'b1 || lsu_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_ready got %b%b want 11", alu_ready, lsu_ready);
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_single_alu();
        alu_valid = 1'b1; alu_rd = 5'd5; alu_data = 32'hDEADBEEF;
        checks++;
        if (alu_ready !== 1'b1) begin
            errors++;
            $display("FAIL single_ready got %b want 1", alu_ready);
        end
        @(negedge clk);
        alu_valid = 1'b0;
        checks++;
        if (rf_we !== 1'b0 || pending !== 32'h20 || busy !== 1'b1) begin
            errors++;
            $display("FAIL single_buf got we=%b pend=%h busy=%b want 0 20 1",
                     rf_we, pending, busy);
        end
        @(negedge clk);
        checks++;
        if (rf_we !== 1'b1 || rf_addr !== 5'd5 || rf_data !== 32'hDEADBEEF
            || pending !== 32'h20) begin
            errors++;
            $display("FAIL single_out got we=%b a=%0d d=%h p=%h want 1 5 deadbeef 20",
                     rf_we, rf_addr, rf_data, pending);
        end
        @(negedge clk);
        checks++;
        if (rf_we !== 1'b0 || pending !== 32'd0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL single_idle got we=%b pend=%h busy=%b want 0 0 0",
                     rf_we, pending, busy);
        end
    endtask

    task automatic test_both();
        alu_valid = 1'b1; alu_rd = 5'd3; alu_data = 32'h11;
        lsu_valid = 1'b1; lsu_rd = 5'd4; lsu_data = 32'h22;
        checks++;
        if (alu_ready !== 1'b1 || lsu_ready !== 1'b1) begin
            errors++;
            $display("FAIL both_ready got %b%b want 11", alu_ready, lsu_ready);
        end
        @(negedge clk);
        alu_valid = 1'b0; lsu_valid = 1'b0;
        checks++;
        if (pending !== 32'h18 || rf_we !== 1'b0) begin
            errors++;
            $display("FAIL both_buf got pend=%h we=%b want 18 0", pending, rf_we);
        end
        @(negedge clk);
        checks++;
        if (rf_we !== 1'b1 || rf_addr !== 5'd4 || rf_data !== 32'h22
            || pending !== 32'h18) begin
            errors++;
            $display("FAIL both_first got we=%b a=%0d d=%h p=%h want 1 4 22 18",
                     rf_we, rf_addr, rf_data, pending);
        end
        @(negedge clk);
        checks++;
        if (rf_we !== 1'b1 || rf_addr !== 5'd3 || rf_data !== 32'h11
            || pending !== 32'h08) begin
            errors++;
            $display("FAIL both_second got we=%b a=%0d d=%h p=%h want 1 3 11 08",
                     rf_we, rf_addr, rf_data, pending);
        end
        @(negedge clk);
        checks++;
        if (rf_we !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL both_idle got we=%b busy=%b want 0 0", rf_we, busy);
        end
    endtask

    task automatic test_rd_zero();
        alu_valid = 1'b1; alu_rd = 5'd0; alu_data = 32'hFFFFFFFF;
        checks++;
        if (alu_ready !== 1'b1) begin
            errors++;
            $display("FAIL rd0_ready got %b want 1", alu_ready);
        end
        @(negedge clk);
        alu_valid = 1'b0;
        checks++;
        if (busy !== 1'b1) begin
            errors++;
            $display("FAIL rd0_busy got %b want 1", busy);
        end
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (rf_we !== 1'b0 || pending !== 32'd0) begin
                errors++;
                $display("FAIL rd0_quiet cyc %0d got we=%b pend=%h want 0 0",
                         i, rf_we, pending);
            end
            @(negedge clk);
        end
    endtask

    task automatic test_contention();
        bit idle;
        alu_valid = 1'b1; alu_rd = 5'd1; alu_data = 32'h100;
        lsu_valid = 1'b1; lsu_rd = 5'd2; lsu_data = 32'h200;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
`ifdef WB_ARB_ROUND_ROBIN_EN
            if (i >= 1) begin
                checks++;
                if (rf_we !== 1'b1 || rf_addr !== ((i % 2 == 1) ? 5'd2 : 5'd1)) begin
                    errors++;
                    $display("FAIL rr_alt cyc %0d got we=%b a=%0d want 1 %0d",
                             i, rf_we, rf_addr, (i % 2 == 1) ? 2 : 1);
                end
            end
`else
            checks++;
            if (alu_ready !== 1'b0) begin
                errors++;
                $display("FAIL fp_alu_ready cyc %0d got %b want 0", i, alu_ready);
            end
            if (i >= 1) begin
                checks++;
                if (rf_we !== 1'b1 || rf_addr !== 5'd2) begin
                    errors++;
                    $display("FAIL fp_lsu cyc %0d got we=%b a=%0d want 1 2",
                             i, rf_we, rf_addr);
                end
            end
`endif
        end
        alu_valid = 1'b0; lsu_valid = 1'b0;
        idle = 1'b0;
        for (int i = 0; i < 10 && !idle; i++) begin
            @(negedge clk);
            idle = !busy;
        end
        checks++;
        if (!idle) begin
            errors++;
            $display("FAIL contention_drain got busy=%b want 0", busy);
        end
    endtask

    task automatic test_reset_midop();
        alu_valid = 1'b1; alu_rd = 5'd9;  alu_data = 32'h99;
        lsu_valid = 1'b1; lsu_rd = 5'd10; lsu_data = 32'hAA;
        @(negedge clk);
        @(negedge clk);
        alu_valid = 1'b0; lsu_valid = 1'b0;
        checks++;
        if (rf_we !== 1'b1 || pending === 32'd0) begin
            errors++;
            $display("FAIL midop_setup got we=%b pend=%h want 1 nonzero",
                     rf_we, pending);
        end
        rst_n = 1'b0;
        #1;
        checks++;
        if (rf_we !== 1'b0 || rf_addr !== 5'd0 || rf_data !== 32'd0
            || pending !== 32'd0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL midop_clear got we=%b a=%0d d=%h p=%h b=%b want all 0",
                     rf_we, rf_addr, rf_data, pending, busy);
        end
        checks++;
        if (alu_ready !== 1'b1 || lsu_ready !== 1'b1) begin
            errors++;
            $display("FAIL midop_ready got %b%b want 11", alu_ready, lsu_ready);
        end
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            checks++;
            if (rf_we !== 1'b0 || busy !== 1'b0) begin
                errors++;
                $display("FAIL midop_quiet cyc %0d got we=%b busy=%b want 0 0",
                         i, rf_we, busy);
            end
        end
    endtask

    task automatic test_same_reg();
        lsu_valid = 1'b1; lsu_rd = 5'd7; lsu_data = 32'hA;
        alu_valid = 1'b1; alu_rd = 5'd7; alu_data = 32'hB;
        @(negedge clk);
        lsu_valid = 1'b0; alu_valid = 1'b0;
        @(negedge clk);
        checks++;
        if (rf_we !== 1'b1 || rf_addr !== 5'd7 || rf_data !== 32'hA
            || pending !== 32'h80) begin
            errors++;
            $display("FAIL same_first got we=%b a=%0d d=%h p=%h want 1 7 a 80",
                     rf_we, rf_addr, rf_data, pending);
        end
        @(negedge clk);
        checks++;
        if (rf_we !== 1'b1 || rf_addr !== 5'd7 || rf_data !== 32'hB) begin
            errors++;
            $display("FAIL same_second got we=%b a=%0d d=%h want 1 7 b",
                     rf_we, rf_addr, rf_data);
        end
        @(negedge clk);
        checks++;
        if (regfile[7] !== 32'hB || rf_we !== 1'b0) begin
            errors++;
            $display("FAIL same_final got r7=%h we=%b want b 0", regfile[7], rf_we);
        end
    endtask

    initial begin
        test_reset();
        test_single_alu();
        test_both();
        test_rd_zero();
        test_contention();
        test_reset_midop();
        test_same_reg();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/wb_arbiter.md
WB_ARBITER -- requirements
Module: wb_arbiter

Interface
REQ-001 SHALL take parameter DATA_WIDTH, default from pkg_config, meaning register data width.
REQ-002 SHALL take parameter NUM_REGISTER, default from pkg_config, meaning architectural register count; AW = $clog2(NUM_REGISTER).
REQ-003 SHALL have port clk_i  input  1  clock; all state updates on rising edge.
REQ-004 SHALL have port rst_n_i  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have ports alu_valid_i input 1, alu_ready_o output 1, alu_rd_addr_i input AW, alu_data_i input DATA_WIDTH: ALU write-back request channel.
REQ-006 SHALL have ports lsu_valid_i input 1, lsu_ready_o output 1, lsu_rd_addr_i input AW, lsu_data_i input DATA_WIDTH: load-unit write-back request channel.
REQ-007 SHALL have ports rf_we_o output 1, rf_rd_addr_o output AW, rf_rd_o output DATA_WIDTH: register-file write port drive.
REQ-008 SHALL have port pending_o  output  NUM_REGISTER  bit i set while a write to register i is buffered or on the rf outputs.
REQ-009 SHALL have port busy_o  output  1  high when any buffer or the output stage holds a write.

Function
REQ-010 SHALL hold one request buffer per channel (valid, addr, data).
REQ-011 SHALL accept a channel request on a rising edge where valid_i and ready_o are both high.
REQ-012 SHALL drive ready_o = buffer empty OR buffer granted in the current cycle (full throughput, no bubble).
REQ-013 SHALL grant combinationally among occupied buffers each cycle; the granted entry loads the output stage at the next edge and its buffer frees.
REQ-014 SHALL register rf_we_o/rf_rd_addr_o/rf_rd_o; rf_we_o high exactly one cycle per granted write; latency acceptance edge -> rf_we_o high = 2 edges.
REQ-015 SHALL accept requests with rd_addr 0 but discard them at grant: no rf_we_o pulse, no pending_o bit, grant slot still consumed.
REQ-016 SHALL, when both buffers hold the same rd_addr, issue both writes in grant order; the register ends with the later-granted data.
REQ-017 SHALL accept on both channels at the same edge when both buffers are free or draining.
REQ-018 SHALL hold a buffered entry stable and keep ready_o low while it loses arbitration.
REQ-019 SHALL compute pending_o as OR of one-hot(addr) over occupied buffers and output stage, excluding register 0.
REQ-020 SHALL drive busy_o = alu buffer valid OR lsu buffer valid OR rf_we_o.

Reset
REQ-021 SHALL, on rst_n_i low, asynchronously clear both buffer valids, rf_we_o=0, rf_rd_addr_o=0, rf_rd_o=0, pending_o=0, busy_o=0, and set arbitration pointer to favour LSU.
REQ-022 SHALL drop any buffered or in-flight writes on reset mid-operation; no rf_we_o pulse after reset release until a new request is accepted.
REQ-023 SHALL drive alu_ready_o and lsu_ready_o high while in reset (buffers empty).

Configuration
REQ-024 SHALL use macro WB_ARB_ROUND_ROBIN_EN to select the arbitration policy.
REQ-025 SHALL, with WB_ARB_ROUND_ROBIN_EN defined, grant round-robin: when both occupied, grant the channel not granted last; pointer updates only on a grant.
REQ-026 SHALL, without WB_ARB_ROUND_ROBIN_EN, grant fixed priority: LSU always wins over ALU.

Verification
REQ-027 SHALL cover: single ALU req rd=5 data=0xDEADBEEF at edge 1 -> rf_we_o=1, rf_rd_addr_o=5, rf_rd_o=0xDEADBEEF during cycle after edge 2; pending_o[5]=1 from edge 1 until rf_we_o drops.
REQ-028 SHALL cover: ALU rd=3 data=0x11 and LSU rd=4 data=0x22 at same edge -> LSU write in first output cycle, ALU write next cycle; both ready_o high at acceptance.
REQ-029 SHALL cover: both channels held valid continuously for 8 cycles (round-robin build) -> grants strictly alternate LSU, ALU, ...; fixed-priority build -> LSU every cycle, alu_ready_o low throughout.
REQ-030 SHALL cover: ALU req rd=0 data=0xFFFFFFFF -> accepted, no rf_we_o pulse, pending_o stays 0.
REQ-031 SHALL cover: both channels write rd=7 (LSU 0xA, ALU 0xB) same edge, round-robin build from reset -> rf writes 0xA then 0xB; final register value 0xB.
REQ-032 SHALL cover: rst_n_i asserted for one cycle with both buffers full -> outputs zero immediately, no write issued after release, ready_o both high.
